ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage 16-bit pipeline.
- Consumes the 91-bit ID/EX bundle and performs forwarding-operand selection, ALU operation, flag (CCR) update, conditional-jump resolution and IN/OUT port handling.
- Registers everything MEM needs into an internal EX/MEM register with stall/flush.
- Latency: one cycle from ID/EX to the EX/MEM output.

Parameters:
- DW, 16, datapath width.
- PCW, 32, program-counter width.
- IDEX_W, 91, ID/EX bundle width.
- EXMEM_W, 79, EX/MEM bundle width.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge, low = reset).
- id_ex  in  91  ID/EX bundle: IOR[0] IOW[1] OPS[2] ALU_OP[5:3] ALU[6] FD[8:7] Data1[24:9] Data2[40:25] WB_Address[43:41] MR[44] MW[45] WB[46] JMP[47] SP[48] SPOP[49] FGS[51:50] PC[83:52] JWSP[84] SRC_Address[87:85] IMM[88] Stack_PC[89] Stack_Flags[90].
- fwd_exmem  in  16  result currently held in EX/MEM.
- fwd_memwb  in  16  write-back value from MEM/WB.
- in_port  in  16  external input port.
- stall  in  1  hold EX/MEM, CCR, out_port.
- flush  in  1  squash the current instruction.
- ex_mem  out  79  registered EX/MEM bundle: Result[15:0] StoreData[31:16] WB_Address[34:32] MR[35] MW[36] WB[37] SP[38] SPOP[39] JWSP[40] Stack_PC[41] Stack_Flags[42] PC[74:43] CCR[77:75] Valid[78].
- ccr  out  3  {C,N,Z}, registered.
- out_port  out  16  registered output port.
- jump_taken  out  1  combinational, to fetch/hazard unit.
- jump_target  out  32  combinational, zero-extended op1.

Behaviour:
Reset:
- rst low at an edge clears ex_mem, ccr and out_port to 0, regardless of stall or flush.
- Reset mid-operation discards the in-flight instruction.

Operands:
- op1 = FD==01 ? fwd_exmem : FD==10 ? fwd_memwb : Data1. FD==11 is treated as 01.
- op2 = Data2, never forwarded. The IMM bit only travels through.

ALU, when ALU=1, keyed by ALU_OP:
- 000 NOT op1; 001 INC op1; 010 DEC op1; 011 ADD op1+op2; 100 SUB op1-op2; 101 AND; 110 OR; 111 MOV op1.
- Arithmetic is a 17-bit sum: C = bit16 for ADD/INC; C = borrow for SUB/DEC.
- Z = (result==0), N = result[15].
- Logic ops and MOV leave C unchanged.

Non-ALU result:
- ALU=0: Result = op1.
- IOR=1 takes priority: Result = in_port.
- StoreData = op2.

Flags (FGS):
- 00 hold; 01 load ALU flags; 10 restore from op1[2:0]; 11 clear.

Jumps (JMP=1, ALU=0):
- ALU_OP 000 unconditional; 001 JZ; 010 JN; 011 JC.
- A taken conditional jump clears the tested flag at the same edge, overriding FGS.
- jump_taken = JMP & condition & ~stall & rst.
- jump_target = {16'b0, op1}.

Output port:
- IOW=1 loads out_port <= op1 at the edge.

Priority at each edge: reset > stall > flush > normal.
- stall=1: ex_mem, ccr, out_port hold.
- flush=1 (no stall): ex_mem cleared to all-zero with Valid=0; ccr and out_port unchanged.
- Normal: ex_mem loaded, Valid=1. The CCR field carries the post-update flags.
- Simultaneous FGS update and jump flag-clear: the clear wins for the tested bit only.

Decomposition:
- Shared package: ID/EX and EX/MEM field offsets, ALU_OP codes, FD codes, FGS codes, jump-condition codes, flag bit indices.
- One combinational sub-module, alu16 (op1, op2, ALU_OP, C_in -> result, Z, N, C).
- ex_stage holds the forwarding mux, CCR, jump logic, out_port and the EX/MEM register.

Test Plan:
- Reset: rst=0 for 2 cycles with random id_ex -> ex_mem=0, ccr=0, out_port=0; first edge after rst=1 loads Valid=1.
- ADD: Data1=0xFFFF, Data2=0x0001, ALU=1, ALU_OP=011, FGS=01 -> Result=0x0000, ccr={C=1,N=0,Z=1} one cycle later.
- Forwarding: FD=10, fwd_memwb=0x1234, Data1=0x0000, ALU_OP=001 -> Result=0x1235; FD=01 with fwd_exmem=0x8000, ALU_OP=111 -> N=1 after FGS=01.
- JZ: ccr Z=1, JMP=1, ALU_OP=001, Data1=0x0040 -> jump_taken=1, jump_target=0x00000040, Z cleared next edge; Z=0 gives jump_taken=0.
- IO: IOW=1, Data1=0xBEEF -> out_port=0xBEEF next cycle; IOR=1, in_port=0x00AA -> Result=0x00AA.
- Stall/flush: stall=1 for 3 cycles -> ex_mem and ccr frozen, jump_taken=0; stall=1 with flush=1 -> hold wins; flush=1 alone -> Valid=0, ccr unchanged.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage: bundle layouts, opcodes, flag bits.
package ex_stage_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned PCW     = 32;
  localparam int unsigned IDEX_W  = 91;
  localparam int unsigned EXMEM_W = 79;
  localparam int unsigned CCR_W   = 3;

  // CCR bit positions, ccr = {C,N,Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;

  // Selected field offsets of the flat bundles
  localparam int unsigned IDEX_DATA1_LSB  = 9;
  localparam int unsigned IDEX_DATA2_LSB  = 25;
  localparam int unsigned IDEX_PC_LSB     = 52;
  localparam int unsigned EXMEM_STORE_LSB = 16;
  localparam int unsigned EXMEM_PC_LSB    = 43;
  localparam int unsigned EXMEM_CCR_LSB   = 75;
  localparam int unsigned EXMEM_VALID_BIT = 78;

  typedef enum logic [2:0] {
    ALU_NOT = 3'b000,
    ALU_INC = 3'b001,
    ALU_DEC = 3'b010,
    ALU_ADD = 3'b011,
    ALU_SUB = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_MOV = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FD_NONE   = 2'b00,
    FD_EXMEM  = 2'b01,
    FD_MEMWB  = 2'b10,
    FD_EXMEM2 = 2'b11
  } fd_e;

  typedef enum logic [1:0] {
    FGS_HOLD    = 2'b00,
    FGS_LOAD    = 2'b01,
    FGS_RESTORE = 2'b10,
    FGS_CLEAR   = 2'b11
  } fgs_e;

  typedef enum logic [2:0] {
    JC_ALWAYS = 3'b000,
    JC_Z      = 3'b001,
    JC_N      = 3'b010,
    JC_C      = 3'b011
  } jcond_e;

  // ID/EX bundle, MSB first (Stack_Flags at bit 90 down to IOR at bit 0)
  typedef struct packed {
    logic          stack_flags;
    logic          stack_pc;
    logic          imm;
    logic [2:0]    src_addr;
    logic          jwsp;
    logic [31:0]   pc;
    logic [1:0]    fgs;
    logic          spop;
    logic          sp;
    logic          jmp;
    logic          wb;
    logic          mw;
    logic          mr;
    logic [2:0]    wb_addr;
    logic [15:0]   data2;
    logic [15:0]   data1;
    logic [1:0]    fd;
    logic          alu;
    logic [2:0]    alu_op;
    logic          ops;
    logic          iow;
    logic          ior;
  } id_ex_t;

  // EX/MEM bundle, MSB first (Valid at bit 78 down to Result at bit 0)
  typedef struct packed {
    logic          valid;
    logic [2:0]    ccr;
    logic [31:0]   pc;
    logic          stack_flags;
    logic          stack_pc;
    logic          jwsp;
    logic          spop;
    logic          sp;
    logic          wb;
    logic          mw;
    logic          mr;
    logic [2:0]    wb_addr;
    logic [15:0]   store_data;
    logic [15:0]   result;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 16-bit ALU; carry is bit 16 of the 17-bit sum (borrow for subtraction).
module alu16
  import ex_stage_pkg::*;
(
  input  logic [DW-1:0] op1,
  input  logic [DW-1:0] op2,
  input  logic [2:0]    alu_op,
  input  logic          c_in,
  output logic [DW-1:0] result_c,
  output logic          z_c,
  output logic          n_c,
  output logic          c_c
);

  localparam int unsigned SW = DW + 1;

  logic [SW-1:0] sum;

  always_comb begin
    sum      = '0;
    result_c = '0;
    c_c      = c_in;
    case (alu_op)
      ALU_NOT: result_c = ~op1;
      ALU_INC: begin
        sum      = SW'(op1) + SW'(1);
        result_c = sum[DW-1:0];
        c_c      = sum[DW];
      end
      ALU_DEC: begin
        sum      = SW'(op1) - SW'(1);
        result_c = sum[DW-1:0];
        c_c      = sum[DW];
      end
      ALU_ADD: begin
        sum      = SW'(op1) + SW'(op2);
        result_c = sum[DW-1:0];
        c_c      = sum[DW];
      end
      ALU_SUB: begin
        sum      = SW'(op1) - SW'(op2);
        result_c = sum[DW-1:0];
        c_c      = sum[DW];
      end
      ALU_AND: result_c = op1 & op2;
      ALU_OR:  result_c = op1 | op2;
      ALU_MOV: result_c = op1;
      default: result_c = op1;
    endcase
    z_c = (result_c == '0);
    n_c = result_c[DW-1];
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, CCR, jump resolution, IN/OUT ports and EX/MEM register.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [IDEX_W-1:0]  id_ex,
  input  logic [DW-1:0]      fwd_exmem,
  input  logic [DW-1:0]      fwd_memwb,
  input  logic [DW-1:0]      in_port,
  input  logic               stall,
  input  logic               flush,
  output logic [EXMEM_W-1:0] ex_mem,
  output logic [CCR_W-1:0]   ccr,
  output logic [DW-1:0]      out_port,
  output logic               jump_taken,
  output logic [PCW-1:0]     jump_target
);

  id_ex_t          ide;
  ex_mem_t         em_q;
  ex_mem_t         em_next;
  logic [DW-1:0]   op1;
  logic [DW-1:0]   alu_res;
  logic            alu_z;
  logic            alu_n;
  logic            alu_c;
  logic            cond;
  logic            jmp_hit;
  logic [CCR_W-1:0] ccr_next;
  logic            unused_fields;

  assign ide           = id_ex_t'(id_ex);
  assign unused_fields = ^{ide.ops, ide.src_addr, ide.imm};

  // Operand 1 forwarding; code 11 aliases the EX/MEM path
  always_comb begin
    case (ide.fd)
      FD_EXMEM, FD_EXMEM2: op1 = fwd_exmem;
      FD_MEMWB:            op1 = fwd_memwb;
      default:             op1 = ide.data1;
    endcase
  end

  alu16 u_alu (
    .op1      (op1),
    .op2      (ide.data2),
    .alu_op   (ide.alu_op),
    .c_in     (ccr[FLAG_C]),
    .result_c (alu_res),
    .z_c      (alu_z),
    .n_c      (alu_n),
    .c_c      (alu_c)
  );

  // Jump condition evaluated against the current (registered) flags
  always_comb begin
    cond = 1'b0;
    case (ide.alu_op)
      JC_ALWAYS: cond = 1'b1;
      JC_Z:      cond = ccr[FLAG_Z];
      JC_N:      cond = ccr[FLAG_N];
      JC_C:      cond = ccr[FLAG_C];
      default:   cond = 1'b0;
    endcase
  end

  assign jmp_hit     = ide.jmp & cond;
  assign jump_taken  = jmp_hit & ~stall & rst;
  assign jump_target = PCW'(op1);

  // Flag update; a taken conditional jump clears only the flag it tested
  always_comb begin
    ccr_next = ccr;
    case (ide.fgs)
      FGS_LOAD:    ccr_next = {alu_c, alu_n, alu_z};
      FGS_RESTORE: ccr_next = op1[CCR_W-1:0];
      FGS_CLEAR:   ccr_next = '0;
      default:     ccr_next = ccr;
    endcase
    if (jmp_hit) begin
      case (ide.alu_op)
        JC_Z:    ccr_next[FLAG_Z] = 1'b0;
        JC_N:    ccr_next[FLAG_N] = 1'b0;
        JC_C:    ccr_next[FLAG_C] = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    em_next             = '0;
    em_next.valid       = 1'b1;
    em_next.ccr         = ccr_next;
    em_next.pc          = ide.pc;
    em_next.stack_flags = ide.stack_flags;
    em_next.stack_pc    = ide.stack_pc;
    em_next.jwsp        = ide.jwsp;
    em_next.spop        = ide.spop;
    em_next.sp          = ide.sp;
    em_next.wb          = ide.wb;
    em_next.mw          = ide.mw;
    em_next.mr          = ide.mr;
    em_next.wb_addr     = ide.wb_addr;
    em_next.store_data  = ide.data2;
    if (ide.ior)      em_next.result = in_port;
    else if (ide.alu) em_next.result = alu_res;
    else              em_next.result = op1;
  end

  // Priority: reset > stall > flush > normal
  always_ff @(posedge clk) begin
    if (!rst) begin
      em_q     <= '0;
      ccr      <= '0;
      out_port <= '0;
    end else if (!stall) begin
      if (flush) begin
        em_q <= '0;
      end else begin
        em_q <= em_next;
        ccr  <= ccr_next;
        if (ide.iow) out_port <= op1;
      end
    end
  end

  assign ex_mem = em_q;

endmodule
